// File: rtl/part2b_register_file.sv
// Eight-entry working-register bank (T1-T4, R1-R4) with a shared clear/load/dec/inc function and two read ports.
// Latency: writes land on the enabling clk edge, reads are zero-cycle combinational; no backpressure, always accepts.
module part2b_register_file #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [2:0]       O1Sel,
  input  logic [2:0]       O2Sel,
  input  logic [1:0]       FunSel,
  input  logic [3:0]       RSel,
  input  logic [3:0]       TSel,
  input  logic [WIDTH-1:0] I,
  output logic [WIDTH-1:0] O1,
  output logic [WIDTH-1:0] O2
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  typedef enum logic [1:0] {
    FUN_CLR = 2'b00,
    FUN_LD  = 2'b01,
    FUN_DEC = 2'b10,
    FUN_INC = 2'b11
  } fun_e;

  // Storage is indexed by the read-select code: 0-3 = T1-T4, 4-7 = R1-R4.
  logic [WIDTH-1:0] regs [8];
  logic [7:0]       en;

  assign en = {RSel[0], RSel[1], RSel[2], RSel[3], TSel[0], TSel[1], TSel[2], TSel[3]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 8; i++) begin
        regs[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 8; i++) begin
        if (en[i]) begin
          case (fun_e'(FunSel))
            FUN_CLR: regs[i] <= '0;
            FUN_LD:  regs[i] <= I;
            FUN_DEC: regs[i] <= regs[i] - ONE;
            FUN_INC: regs[i] <= regs[i] + ONE;
            default: regs[i] <= regs[i];
          endcase
        end
      end
    end
  end

  assign O1 = regs[O1Sel];
  assign O2 = regs[O2Sel];

endmodule

// File: tb/tb_part2b_register_file.sv
// Self-checking bench for part2b_register_file: reference model plus expected-value queue per read sweep.
module tb_part2b_register_file;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] O1Sel, O2Sel;
  logic [1:0] FunSel;
  logic [3:0] RSel, TSel;
  logic [7:0] I;
  logic [7:0] O1, O2;

  int checks = 0;
  int errors = 0;

  // Model indexed by select code: 0-3 = T1-T4, 4-7 = R1-R4.
  logic [7:0] model [8];
  logic [7:0] exp_q [$];
  logic [7:0] e;

  part2b_register_file #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .O1Sel(O1Sel), .O2Sel(O2Sel), .FunSel(FunSel),
    .RSel(RSel), .TSel(TSel), .I(I), .O1(O1), .O2(O2)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // Drives one operation for a single edge, then updates the reference model and drops enables.
  task automatic clk_op(input logic [1:0] f, input logic [3:0] rs, input logic [3:0] ts, input logic [7:0] d);
    logic en;
    @(negedge clk);
    FunSel = f; RSel = rs; TSel = ts; I = d;
    @(posedge clk);
    #1;
    for (int i = 0; i < 8; i++) begin
      en = (i < 4) ? ts[3-i] : rs[7-i];
      if (en) begin
        case (f)
          2'b00: model[i] = 8'h00;
          2'b01: model[i] = d;
          2'b10: model[i] = model[i] - 8'd1;
          default: model[i] = model[i] + 8'd1;
        endcase
      end
    end
    RSel = 4'b0000; TSel = 4'b0000;
  endtask

  task automatic test_power_on;
    rst = 1'b1; FunSel = 2'b11; RSel = 4'b1111; TSel = 4'b1111; I = 8'hFF;
    O1Sel = 3'd0; O2Sel = 3'd0;
    for (int i = 0; i < 8; i++) model[i] = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    for (int s = 0; s < 8; s++) begin
      O1Sel = 3'(s); O2Sel = 3'(7 - s);
      exp_q.push_back(8'h00); exp_q.push_back(8'h00);
      #1;
      e = exp_q.pop_front(); checks++;
      if (O1 !== e) begin errors++; $display("FAIL power_on O1 sel=%0d got=%h exp=%h", s, O1, e); end
      e = exp_q.pop_front(); checks++;
      if (O2 !== e) begin errors++; $display("FAIL power_on O2 sel=%0d got=%h exp=%h", 7 - s, O2, e); end
    end
    RSel = 4'b0000; TSel = 4'b0000;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_increment;
    for (int k = 0; k < 4; k++) clk_op(2'b11, 4'b0001, 4'b0000, 8'h00);
    O1Sel = 3'b111; O2Sel = 3'b000;
    exp_q.push_back(8'd4); exp_q.push_back(8'd0);
    #1;
    e = exp_q.pop_front(); checks++;
    if (O1 !== e) begin errors++; $display("FAIL inc_r4 O1 got=%h exp=%h", O1, e); end
    e = exp_q.pop_front(); checks++;
    if (O2 !== e) begin errors++; $display("FAIL inc_r4 O2 got=%h exp=%h", O2, e); end
    for (int s = 0; s < 7; s++) begin
      O1Sel = 3'(s);
      exp_q.push_back(8'd0);
      #1;
      e = exp_q.pop_front(); checks++;
      if (O1 !== e) begin errors++; $display("FAIL inc_others sel=%0d got=%h exp=%h", s, O1, e); end
    end
  endtask

  task automatic test_load_dec;
    clk_op(2'b01, 4'b1000, 4'b1000, 8'h04);
    O1Sel = 3'b100; O2Sel = 3'b000;
    exp_q.push_back(8'd4); exp_q.push_back(8'd4);
    #1;
    e = exp_q.pop_front(); checks++;
    if (O1 !== e) begin errors++; $display("FAIL load R1 got=%h exp=%h", O1, e); end
    e = exp_q.pop_front(); checks++;
    if (O2 !== e) begin errors++; $display("FAIL load T1 got=%h exp=%h", O2, e); end
    clk_op(2'b10, 4'b1000, 4'b1000, 8'h00);
    clk_op(2'b10, 4'b1000, 4'b1000, 8'h00);
    exp_q.push_back(8'd2); exp_q.push_back(8'd2);
    #1;
    e = exp_q.pop_front(); checks++;
    if (O1 !== e) begin errors++; $display("FAIL dec R1 got=%h exp=%h", O1, e); end
    e = exp_q.pop_front(); checks++;
    if (O2 !== e) begin errors++; $display("FAIL dec T1 got=%h exp=%h", O2, e); end
  endtask

  task automatic test_wrap;
    O1Sel = 3'b010; O2Sel = 3'b010;
    clk_op(2'b01, 4'b0000, 4'b0010, 8'hFF);
    clk_op(2'b11, 4'b0000, 4'b0010, 8'h00);
    exp_q.push_back(8'h00);
    #1;
    e = exp_q.pop_front(); checks++;
    if (O1 !== e) begin errors++; $display("FAIL wrap_inc T3 got=%h exp=%h", O1, e); end
    clk_op(2'b10, 4'b0000, 4'b0010, 8'h00);
    exp_q.push_back(8'hFF);
    #1;
    e = exp_q.pop_front(); checks++;
    if (O2 !== e) begin errors++; $display("FAIL wrap_dec T3 got=%h exp=%h", O2, e); end
  endtask

  task automatic test_multi_clear;
    clk_op(2'b01, 4'b1111, 4'b1111, 8'h5A);
    for (int s = 0; s < 8; s++) begin
      O1Sel = 3'(s);
      exp_q.push_back(8'h5A);
      #1;
      e = exp_q.pop_front(); checks++;
      if (O1 !== e) begin errors++; $display("FAIL multi_load sel=%0d got=%h exp=%h", s, O1, e); end
    end
    clk_op(2'b00, 4'b0101, 4'b0000, 8'hEE);
    for (int s = 0; s < 8; s++) begin
      O2Sel = 3'(s);
      exp_q.push_back((s == 5 || s == 7) ? 8'h00 : 8'h5A);
      #1;
      e = exp_q.pop_front(); checks++;
      if (O2 !== e) begin errors++; $display("FAIL clear sel=%0d got=%h exp=%h", s, O2, e); end
    end
  endtask

  task automatic test_hold_dual_read;
    clk_op(2'b01, 4'b0010, 4'b0100, 8'hC3);
    clk_op(2'b11, 4'b0000, 4'b0001, 8'h00);
    for (int k = 0; k < 4; k++) clk_op(2'(k), 4'b0000, 4'b0000, 8'hAA);
    for (int s = 0; s < 8; s++) begin
      O1Sel = 3'(s); O2Sel = 3'(7 - s);
      exp_q.push_back(model[s]); exp_q.push_back(model[7 - s]);
      #1;
      e = exp_q.pop_front(); checks++;
      if (O1 !== e) begin errors++; $display("FAIL hold O1 sel=%0d got=%h exp=%h", s, O1, e); end
      e = exp_q.pop_front(); checks++;
      if (O2 !== e) begin errors++; $display("FAIL hold O2 sel=%0d got=%h exp=%h", 7 - s, O2, e); end
    end
    for (int s = 0; s < 8; s++) begin
      O1Sel = 3'(s); O2Sel = 3'(s);
      exp_q.push_back(model[s]); exp_q.push_back(model[s]);
      #1;
      e = exp_q.pop_front(); checks++;
      if (O1 !== e) begin errors++; $display("FAIL same_sel O1 sel=%0d got=%h exp=%h", s, O1, e); end
      e = exp_q.pop_front(); checks++;
      if (O2 !== e) begin errors++; $display("FAIL same_sel O2 sel=%0d got=%h exp=%h", s, O2, e); end
    end
  endtask

  task automatic test_async_reset;
    clk_op(2'b01, 4'b1111, 4'b1111, 8'h33);
    @(posedge clk);
    #2;
    FunSel = 2'b11; RSel = 4'b1111; TSel = 4'b1111;
    rst = 1'b1;
    for (int i = 0; i < 8; i++) model[i] = 8'h00;
    O1Sel = 3'd4; O2Sel = 3'd0;
    exp_q.push_back(8'h00); exp_q.push_back(8'h00);
    #1;
    e = exp_q.pop_front(); checks++;
    if (O1 !== e) begin errors++; $display("FAIL async_rst immediate O1 got=%h exp=%h", O1, e); end
    e = exp_q.pop_front(); checks++;
    if (O2 !== e) begin errors++; $display("FAIL async_rst immediate O2 got=%h exp=%h", O2, e); end
    for (int s = 0; s < 8; s++) begin
      O1Sel = 3'(s); O2Sel = 3'(7 - s);
      exp_q.push_back(8'h00); exp_q.push_back(8'h00);
      #2;
      e = exp_q.pop_front(); checks++;
      if (O1 !== e) begin errors++; $display("FAIL async_rst O1 sel=%0d got=%h exp=%h", s, O1, e); end
      e = exp_q.pop_front(); checks++;
      if (O2 !== e) begin errors++; $display("FAIL async_rst O2 sel=%0d got=%h exp=%h", 7 - s, O2, e); end
    end
    RSel = 4'b0000; TSel = 4'b0000;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    test_power_on();
    test_increment();
    test_load_dec();
    test_wrap();
    test_multi_clear();
    test_hold_dual_read();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
